// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, trap cause codes, mstatus bit positions and FSM encoding
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_MEI      = 11;
    localparam int IRQ_MTI      = 7;
    localparam logic [31:0] MIE_MASK = 32'h0000_0880;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with increment and independent 32-bit half writes
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] q
);
    // a half write suppresses the increment and leaves the other half untouched
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (wr_lo) q <= {q[63:32], wdata};
        else if (wr_hi) q <= {wdata, q[31:0]};
        else q <= q + {63'b0, inc};
    end
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file, CSRRW/RS/RC execution, trap/MRET arbitration and redirect
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [11:0] csr_add,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic        csr_set,
    input  logic        csr_clear,
    input  logic [31:0] csr_wdata,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        illegal_inst,
    input  logic        mret_in,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        trap,
    output logic        mret,
    output logic [31:0] redirect_pc
);
    logic [0:0]  state;
    logic        mst_mie, mst_mpie;
    logic [31:0] mie_r, mtvec, mscratch, mepc, mcause, mtval;
    logic [63:0] mcycle, minstret;
    logic [31:0] old_val, new_val, cause, base, vec_off;
    logic        impl, act, csr_op, wr_req, ro, illegal, irq_e, irq_t, do_wr;

    always_comb begin
        impl = 1'b1;
        old_val = '0;
        case (csr_add)
            CSR_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
            CSR_MISA:      old_val = MISA_VAL;
            CSR_MIE:       old_val = mie_r;
            CSR_MTVEC:     old_val = mtvec;
            CSR_MSCRATCH:  old_val = mscratch;
            CSR_MEPC:      old_val = mepc;
            CSR_MCAUSE:    old_val = mcause;
            CSR_MTVAL:     old_val = mtval;
            CSR_MIP:       old_val = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};
            CSR_MCYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH:   old_val = mcycle[63:32];
            CSR_MINSTRET:  old_val = minstret[31:0];
            CSR_MINSTRETH: old_val = minstret[63:32];
            CSR_MHARTID:   old_val = HART_ID;
            default:       impl = 1'b0;
        endcase
    end

    assign act     = ex_valid & (state == ST_RUN);
    assign csr_op  = csr_read | csr_write | csr_set | csr_clear;
    assign wr_req  = csr_write | ((csr_set | csr_clear) & (|csr_wdata));
    assign new_val = csr_write ? csr_wdata : csr_set ? (old_val | csr_wdata) : (old_val & ~csr_wdata);
    assign ro      = (&csr_add[11:10]) | (csr_add == CSR_MIP);
    assign illegal = illegal_inst | (csr_op & (~impl | (wr_req & ro)));
    assign irq_e   = mst_mie & mie_r[IRQ_MEI] & ext_irq;
    assign irq_t   = mst_mie & mie_r[IRQ_MTI] & timer_irq;
    assign cause   = irq_e ? CAUSE_MEI : irq_t ? CAUSE_MTI : illegal ? CAUSE_ILLEGAL :
                     ebreak ? CAUSE_EBREAK : CAUSE_ECALL;
    assign trap    = act & (irq_e | irq_t | illegal | ebreak | ecall);
    assign mret    = act & mret_in & ~trap;
    assign do_wr   = act & ~trap & ~mret_in & wr_req;

    // vectored mode only offsets interrupts; exceptions always land on the base
    assign base    = {mtvec[31:2], 2'b00};
    assign vec_off = (mtvec[1:0] == 2'b01 && cause[31]) ? {25'b0, cause[4:0], 2'b00} : 32'b0;
    assign redirect_pc = trap ? base + vec_off : mret ? mepc : 32'b0;
    assign csr_rdata   = (ex_valid & csr_read) ? old_val : 32'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            mst_mie  <= 1'b0;
            mst_mpie <= 1'b0;
            mie_r    <= '0;
            mtvec    <= MTVEC_RESET;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else begin
            state <= (state == ST_RUN && (trap | mret)) ? ST_FLUSH : ST_RUN;
            if (trap) begin
                mepc     <= ex_pc & ~32'h3;
                mcause   <= cause;
                mtval    <= (cause == CAUSE_EBREAK) ? ex_pc : 32'b0;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (do_wr) begin
                case (csr_add)
                    CSR_MSTATUS: begin
                        mst_mie  <= new_val[MSTATUS_MIE];
                        mst_mpie <= new_val[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_r    <= new_val & MIE_MASK;
                    CSR_MTVEC:    mtvec    <= new_val;
                    CSR_MSCRATCH: mscratch <= new_val;
                    CSR_MEPC:     mepc     <= new_val & ~32'h3;
                    CSR_MCAUSE:   mcause   <= new_val;
                    CSR_MTVAL:    mtval    <= new_val;
                    default: ;
                endcase
            end
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (do_wr && csr_add == CSR_MCYCLE),
        .wr_hi (do_wr && csr_add == CSR_MCYCLEH),
        .wdata (new_val),
        .q     (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (act & ~trap),
        .wr_lo (do_wr && csr_add == CSR_MINSTRET),
        .wr_hi (do_wr && csr_add == CSR_MINSTRETH),
        .wdata (new_val),
        .q     (minstret)
    );
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed and random checks of csr_trap_unit against a CSR/trap reference model
module tb_csr_trap_unit;
    localparam logic [31:0] MISA = 32'h4000_0100;

    logic        clk, rst, ex_valid, csr_read, csr_write, csr_set, csr_clear;
    logic        ecall, ebreak, illegal_inst, mret_in, ext_irq, timer_irq, trap, mret;
    logic [31:0] ex_pc, csr_wdata, csr_rdata, redirect_pc;
    logic [11:0] csr_add;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] s_rdata, s_redir, h0;
    logic        s_trap, s_mret;

    logic [31:0] m [logic [11:0]];
    logic [63:0] cyc, ins;
    bit          fl;

    csr_trap_unit dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .csr_add(csr_add),
        .csr_read(csr_read), .csr_write(csr_write), .csr_set(csr_set), .csr_clear(csr_clear),
        .csr_wdata(csr_wdata), .ecall(ecall), .ebreak(ebreak), .illegal_inst(illegal_inst),
        .mret_in(mret_in), .ext_irq(ext_irq), .timer_irq(timer_irq), .csr_rdata(csr_rdata),
        .trap(trap), .mret(mret), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
    endfunction

    function automatic logic [31:0] rd(input logic [11:0] a);
        case (a)
            12'h301: return MISA;
            12'h344: return (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0);
            12'hB00: return cyc[31:0];
            12'hB80: return cyc[63:32];
            12'hB02: return ins[31:0];
            12'hB82: return ins[63:32];
            12'hF14: return 32'd0;
            default: return m.exists(a) ? m[a] : 32'd0;
        endcase
    endfunction

    task automatic mreset();
        m[12'h300] = 32'h1800; m[12'h304] = 0; m[12'h305] = 32'h100; m[12'h340] = 0;
        m[12'h341] = 0; m[12'h342] = 0; m[12'h343] = 0;
        cyc = 0; ins = 0; fl = 0;
    endtask

    // one clock: inputs already driven; check outputs before the edge, advance the model at the edge
    task automatic tick();
        logic [31:0] ms, mi, tv, old, nv, ec, er, ed;
        bit op, wen, ro, ill, pe, pt, act, et, em, wr;
        #2;
        ms  = m[12'h300]; mi = m[12'h304]; tv = m[12'h305];
        old = rd(csr_add);
        nv  = csr_write ? csr_wdata : csr_set ? (old | csr_wdata) : (old & ~csr_wdata);
        op  = csr_read | csr_write | csr_set | csr_clear;
        wen = csr_write || ((csr_set || csr_clear) && csr_wdata != 0);
        ro  = (csr_add >= 12'hC00) || csr_add == 12'h344;
        ill = illegal_inst || (op && (!is_impl(csr_add) || (wen && ro)));
        pe  = ms[3] && mi[11] && ext_irq;
        pt  = ms[3] && mi[7] && timer_irq;
        act = ex_valid && !fl;
        et  = act && (pe || pt || ill || ebreak || ecall);
        em  = act && mret_in && !et;
        ec  = pe ? 32'h8000_000B : pt ? 32'h8000_0007 : ill ? 2 : ebreak ? 3 : 11;
        er  = (ex_valid && csr_read) ? rd(csr_add) : 0;
        ed  = et ? (tv & ~32'h3) + ((tv[1:0] == 2'b01 && ec[31]) ? (ec & 32'h1F) * 4 : 0)
                 : em ? m[12'h341] : 0;
        wr  = act && !et && !mret_in && wen;
        s_rdata = csr_rdata; s_trap = trap; s_mret = mret; s_redir = redirect_pc;
        if (!rst) begin
            chk("trap", {31'b0, s_trap}, {31'b0, et});
            chk("mret", {31'b0, s_mret}, {31'b0, em});
            chk("csr_rdata", s_rdata, er);
            chk("redirect_pc", s_redir, ed);
        end
        @(posedge clk);
        if (rst) mreset();
        else begin
            if (wr && csr_add == 12'hB00) cyc = {cyc[63:32], nv};
            else if (wr && csr_add == 12'hB80) cyc = {nv, cyc[31:0]};
            else cyc = cyc + 1;
            if (wr && csr_add == 12'hB02) ins = {ins[63:32], nv};
            else if (wr && csr_add == 12'hB82) ins = {nv, ins[31:0]};
            else if (act && !et) ins = ins + 1;
            if (et) begin
                m[12'h341] = ex_pc & ~32'h3;
                m[12'h342] = ec;
                m[12'h343] = (ec == 3) ? ex_pc : 0;
                m[12'h300] = 32'h1800 | (ms[3] ? 32'h80 : 0);
            end else if (em) m[12'h300] = 32'h1880 | (ms[7] ? 32'h8 : 0);
            else if (wr) begin
                case (csr_add)
                    12'h300: m[csr_add] = 32'h1800 | (nv & 32'h88);
                    12'h304: m[csr_add] = nv & 32'h880;
                    12'h341: m[csr_add] = nv & ~32'h3;
                    12'h305, 12'h340, 12'h342, 12'h343: m[csr_add] = nv;
                    default: ;
                endcase
            end
            fl = et || em;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        ex_valid = 0; ex_pc = 0; csr_add = 0; csr_read = 0; csr_write = 0; csr_set = 0;
        csr_clear = 0; csr_wdata = 0; ecall = 0; ebreak = 0; illegal_inst = 0; mret_in = 0;
        ext_irq = 0; timer_irq = 0;
    endtask

    // k: 0 read, 1 write, 2 set, 3 clear
    task automatic csr(input logic [11:0] a, input int k, input logic [31:0] d);
        idle(); ex_valid = 1; ex_pc = 32'h1000; csr_add = a; csr_read = 1;
        csr_write = (k == 1); csr_set = (k == 2); csr_clear = (k == 3); csr_wdata = d;
        tick();
    endtask

    task automatic insn(input logic [31:0] pc, input logic ec, input logic mr, input logic ei, input logic ti);
        idle(); ex_valid = 1; ex_pc = pc; ecall = ec; mret_in = mr; ext_irq = ei; timer_irq = ti;
        tick();
    endtask

    localparam logic [11:0] ALIST [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
        12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h123};

    initial begin
        idle(); rst = 1; mreset();
        @(negedge clk);
        tick(); tick();
        rst = 0;
        csr(12'h305, 0, 0); chk("rst_mtvec", s_rdata, 32'h100);
        csr(12'h301, 0, 0); chk("misa", s_rdata, MISA);
        csr(12'hF14, 0, 0); chk("mhartid", s_rdata, 32'd0);
        csr(12'hB00, 0, 0); chk("mcycle_3", s_rdata, 32'd3);
        csr(12'hB00, 0, 0); chk("mcycle_4", s_rdata, 32'd4);
        csr(12'h300, 2, 32'h8);
        csr(12'h300, 3, 32'h8); chk("mstatus_set", s_rdata, 32'h1808);
        csr(12'h300, 0, 0);     chk("mstatus_clr", s_rdata, 32'h1800);
        insn(32'h40, 1, 0, 0, 0); chk("ecall_trap", {31'b0, s_trap}, 32'd1); chk("ecall_pc", s_redir, 32'h100);
        insn(32'h44, 1, 0, 0, 0); chk("flush_trap", {31'b0, s_trap}, 32'd0);
        csr(12'h341, 0, 0); chk("ecall_mepc", s_rdata, 32'h40);
        csr(12'h342, 0, 0); chk("ecall_mcause", s_rdata, 32'd11);
        csr(12'h300, 2, 32'h8);
        csr(12'h304, 1, 32'h880);
        csr(12'h305, 1, 32'h201);
        insn(32'h80, 0, 0, 0, 1); chk("mti_pc", s_redir, 32'h21C);
        idle(); tick();
        csr(12'h342, 0, 0); chk("mti_cause", s_rdata, 32'h8000_0007);
        csr(12'h300, 0, 0); chk("mti_mstatus", s_rdata, 32'h1880);
        csr(12'h341, 1, 32'h44);
        insn(32'h60, 0, 1, 0, 0); chk("mret", {31'b0, s_mret}, 32'd1); chk("mret_pc", s_redir, 32'h44);
        idle(); tick();
        csr(12'h300, 0, 0); chk("mret_mstatus", s_rdata, 32'h1888);
        insn(32'h90, 1, 0, 1, 0); chk("mei_pc", s_redir, 32'h22C);
        idle(); tick();
        csr(12'h342, 0, 0); chk("mei_cause", s_rdata, 32'h8000_000B);
        csr(12'hF14, 1, 32'h5); chk("ro_trap", {31'b0, s_trap}, 32'd1); chk("ro_pc", s_redir, 32'h200);
        idle(); tick();
        csr(12'h342, 0, 0); chk("ro_cause", s_rdata, 32'd2);
        csr(12'hF14, 0, 0); chk("ro_unchanged", s_rdata, 32'd0);
        csr(12'h342, 1, 32'h0);
        csr(12'h7C0, 1, 32'h5); chk("unimpl_trap", {31'b0, s_trap}, 32'd1);
        idle(); tick();
        csr(12'h342, 0, 0); chk("unimpl_cause", s_rdata, 32'd2);
        csr(12'hB80, 0, 0); h0 = s_rdata;
        csr(12'hB00, 1, 32'hFFFF_FFFF);
        csr(12'hB00, 0, 0); chk("mcycle_wr", s_rdata, 32'hFFFF_FFFF);
        csr(12'hB80, 0, 0); chk("mcycleh_carry", s_rdata, h0 + 1);
        idle(); csr_read = 1; csr_add = 12'h305; ecall = 1; tick();
        chk("bubble_trap", {31'b0, s_trap}, 32'd0); chk("bubble_rdata", s_rdata, 32'd0);
        insn(32'h40, 1, 0, 0, 0);
        idle(); rst = 1; tick(); rst = 0;
        csr(12'h342, 0, 0); chk("rst_mcause", s_rdata, 32'd0);
        insn(32'h48, 1, 0, 0, 0); chk("rst_run_trap", {31'b0, s_trap}, 32'd1);
        for (int i = 0; i < 400; i++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            ex_valid = ($urandom_range(0, 7) != 0);
            ex_pc = $urandom & ~32'h3;
            csr_add = ALIST[$urandom_range(0, 15)];
            case ($urandom_range(0, 4))
                1: csr_read = 1;
                2: begin csr_read = 1; csr_write = 1; end
                3: begin csr_read = 1; csr_set = 1; end
                4: begin csr_read = 1; csr_clear = 1; end
                default: ;
            endcase
            csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            ecall = ($urandom_range(0, 15) == 0);
            ebreak = ($urandom_range(0, 15) == 0);
            illegal_inst = ($urandom_range(0, 15) == 0);
            mret_in = ($urandom_range(0, 11) == 0);
            ext_irq = ($urandom_range(0, 3) == 0);
            timer_irq = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
